regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 145 ++++++++++++++
 tb/tb_regfile_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Two-read/one-write register file with per-entry pending flags and a
// sequenced bulk clear. Optional write-to-read bypass: REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy1,
    output logic              busy2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t state;
    state_t stateNext;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [ADDR_W-1:0] clrCnt;
    logic              doneQ;

    logic inIdle;
    logic inClear;
    logic lastClr;
    logic wrEn;
    logic issueEn;
    logic bypass1;
    logic bypass2;

    assign inIdle  = (state == IDLE);
    assign inClear = (state == CLEAR);
    assign lastClr = inClear && (clrCnt == LAST);
    assign wrEn    = we && (waddr != '0) && inIdle;
    assign issueEn = issue_valid && (issue_addr != '0) && inIdle;

    // State register for the bulk-clear sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: start on a request in IDLE, return after the last entry
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    stateNext = CLEAR;
                end
            end
            CLEAR: begin
                if (lastClr) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Clear address counter and the completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clrCnt <= '0;
            doneQ  <= 1'b0;
        end else begin
            doneQ <= lastClr;
            if (inIdle && clr_req) begin
                clrCnt <= ADDR_W'(1);
            end else if (inClear) begin
                clrCnt <= clrCnt + ADDR_W'(1);
            end
        end
    end

    // Storage: clear walk, normal writes, then issue marks (issue wins)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else if (inClear) begin
            regs[clrCnt]    <= '0;
            pending[clrCnt] <= 1'b0;
        end else begin
            if (wrEn) begin
                regs[waddr]    <= wdata;
                pending[waddr] <= 1'b0;
            end
            if (issueEn) begin
                pending[issue_addr] <= 1'b1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign bypass1 = wrEn && (raddr1 == waddr);
    assign bypass2 = wrEn && (raddr2 == waddr);
`else
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    // Combinational read ports; entry 0 is hardwired to zero and never busy
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        busy1  = 1'b0;
        busy2  = 1'b0;
        if (raddr1 != '0) begin
            rdata1 = bypass1 ? wdata : regs[raddr1];
            busy1  = !bypass1 && pending[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = bypass2 ? wdata : regs[raddr2];
            busy2  = !bypass2 && pending[raddr2];
        end
    end

    assign clr_busy = inClear;
    assign clr_done = doneQ;

endmodule

// File: tb/tb_regfile_param.sv
// Randomized bench for regfile_param against an array-based reference model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_param;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        busy1;
    logic        busy2;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    regfile_param #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .busy1(busy1), .busy2(busy2), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [31:0] mem [32];
    bit          pend [32];
    bit          mClear;
    int          mIdx;
    bit          mDone;

    int nChecks = 0;
    int nFails  = 0;
    int busyCycles;
    int donePulses;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
        mClear = 1'b0;
        mIdx   = 0;
        mDone  = 1'b0;
    endtask

    function automatic bit bypassHit(input logic [4:0] ra);
`ifdef REGFILE_BYPASS_EN
        return we && waddr != 0 && !mClear && ra == waddr;
`else
        return 1'b0;
`endif
    endfunction

    // One cycle: apply inputs, check mid-cycle outputs, clock, update model
    task automatic drive(input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic iv,
                         input logic [4:0] ia, input logic cr);
        logic [31:0] e1, e2;
        logic        b1, b2;
        we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
        issue_valid = iv; issue_addr = ia; clr_req = cr;
        #2;
        e1 = (r1 == 0) ? 32'h0 : (bypassHit(r1) ? wd : mem[r1]);
        e2 = (r2 == 0) ? 32'h0 : (bypassHit(r2) ? wd : mem[r2]);
        b1 = (r1 != 0) && !bypassHit(r1) && pend[r1];
        b2 = (r2 != 0) && !bypassHit(r2) && pend[r2];
        check("rdata1", 64'(rdata1), 64'(e1));
        check("rdata2", 64'(rdata2), 64'(e2));
        check("busy1", 64'(busy1), 64'(b1));
        check("busy2", 64'(busy2), 64'(b2));
        check("clr_busy", 64'(clr_busy), 64'(mClear));
        check("clr_done", 64'(clr_done), 64'(mDone));
        if (clr_busy) busyCycles++;
        if (clr_done) donePulses++;
        @(posedge clk);
        if (mClear) begin
            mem[mIdx]  = '0;
            pend[mIdx] = 1'b0;
            mDone      = 1'b0;
            if (mIdx == 31) begin
                mClear = 1'b0;
                mDone  = 1'b1;
            end else begin
                mIdx++;
            end
        end else begin
            mDone = 1'b0;
            if (w && wa != 0) begin
                mem[wa]  = wd;
                pend[wa] = 1'b0;
            end
            if (iv && ia != 0) pend[ia] = 1'b1;
            if (cr) begin
                mClear = 1'b1;
                mIdx   = 1;
            end
        end
        #1;
    endtask

    task automatic idleRead(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 5'd0, 32'h0, r1, r2, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic randCycle(input int clrOdds);
        drive(1'($urandom), 5'($urandom), $urandom, 5'($urandom),
              5'($urandom), 1'($urandom),
              5'($urandom), ($urandom_range(clrOdds - 1) == 0));
    endtask

    // Assert reset asynchronously, check every entry reads zero, release
    task automatic doReset();
        rst = 1'b1;
        we = 0; issue_valid = 0; clr_req = 0;
        #1;
        modelReset();
        check("rst_clr_busy", 64'(clr_busy), 64'(0));
        check("rst_clr_done", 64'(clr_done), 64'(0));
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check("rst_rdata1", 64'(rdata1), 64'(0));
            check("rst_busy2", 64'(busy2), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        we = 0; waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0;
        issue_valid = 0; issue_addr = 0; clr_req = 0;
        modelReset();
        doReset();

        // Basic write/read and r0 immunity
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idleRead(5'd5, 5'd5);
        check("r5_literal", 64'(rdata1), 64'h0000_0000_DEAD_BEEF);
        drive(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        idleRead(5'd0, 5'd0);
        check("r0_literal", 64'(rdata1), 64'(0));

        // Pending flags: issue, write-clears, same-cycle issue+write
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0);
        idleRead(5'd0, 5'd7);
        check("busy2_r7", 64'(busy2), 64'(1));
        drive(1'b1, 5'd7, 32'h55, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        idleRead(5'd0, 5'd7);
        check("busy2_r7_cleared", 64'(busy2), 64'(0));
        drive(1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        idleRead(5'd9, 5'd9);
        check("busy1_r9", 64'(busy1), 64'(1));
        check("rdata1_r9", 64'(rdata1), 64'h99);

        // Write and read the same address in one cycle
        drive(1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0);
        idleRead(5'd3, 5'd0);
        check("r3_after", 64'(rdata1), 64'hA5A5A5A5);

        // Random traffic with occasional clears
        for (int i = 0; i < 400; i++) randCycle(40);
        for (int i = 0; i < 40; i++) randCycle(1000);

        // Fill everything, then clear under hostile traffic
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), $urandom | 32'h1, 5'($urandom), 5'($urandom),
                  1'b1, 5'($urandom), 1'b0);
        end
        busyCycles = 0;
        donePulses = 0;
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 31; i++) begin
            drive(1'b1, 5'($urandom), $urandom | 32'h1, 5'($urandom),
                  5'($urandom), 1'b1, 5'($urandom), 1'b1);
        end
        for (int i = 0; i < 3; i++) idleRead(5'd0, 5'd0);
        check("clear_busy_cycles", 64'(busyCycles), 64'(31));
        check("clear_done_pulses", 64'(donePulses), 64'(1));
        for (int i = 0; i < 32; i++) idleRead(5'(i), 5'(31 - i));

        // Clear requested again right as the previous one ends
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 31; i++) randCycle(1);
        for (int i = 0; i < 34; i++) randCycle(1000);

        // Reset during a clear
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), $urandom | 32'h1, 5'($urandom), 5'($urandom),
                  1'($urandom), 5'($urandom), 1'b0);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 10; i++) randCycle(1000);
        doReset();
        donePulses = 0;
        for (int i = 0; i < 40; i++) idleRead(5'($urandom), 5'($urandom));
        check("abort_no_done", 64'(donePulses), 64'(0));

        for (int i = 0; i < 200; i++) randCycle(60);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
